// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT display pipeline.
// Scheduler state encoding is fixed because o_state drives debug LEDs.
package fft_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        FFT     = 3'd2,
        WAIT_VS = 3'd3,
        SWAP    = 3'd4
    } sched_state_t;

    localparam int unsigned N_POINTS = 512;
    localparam int unsigned LOG2_N   = 9;

endpackage

// File: rtl/fft_frame_scheduler_vs_edge_det.sv
// Vsync leading-edge detector. One-cycle o_vs_edge when i_vs first reaches its active level.
// The history register freezes with i_en, so a pulse hidden while disabled is not seen later.
module vs_edge_det #(
    parameter bit VS_ACTIVE_LOW = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_vs,
    output logic o_vs_edge
);

    localparam logic VS_ACT = VS_ACTIVE_LOW ? 1'b0 : 1'b1;

    logic r_vs_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vs_prev <= ~VS_ACT;
        end else if (i_en) begin
            r_vs_prev <= i_vs;
        end
    end

    assign o_vs_edge = i_en && (i_vs == VS_ACT) && (r_vs_prev != VS_ACT);

endmodule

// File: rtl/fft_frame_scheduler.sv
// Frame sequencer: capture -> FFT -> wait for vsync -> swap result banks.
// Capture/FFT write the back bank; the grapher reads the front bank, swapped only at vsync.
module fft_frame_scheduler
    import fft_pkg::*;
#(
    parameter bit          VS_ACTIVE_LOW  = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned TIMER_W        = 21
) (
    input  logic       i_clk_24MHz,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_vs,
    output logic       o_cap_start,
    input  logic       i_cap_done,
    output logic       o_fft_start,
    input  logic       i_fft_done,
    output logic       o_wr_bank,
    output logic       o_rd_bank,
    output logic [7:0] o_frame_cnt,
    output logic       o_timeout,
    output logic [2:0] o_state
);

    logic               w_vs_edge;
    logic               w_timer_exp;

    sched_state_t       r_state;
    logic [TIMER_W-1:0] r_timer;
    logic               r_cap_start;
    logic               r_fft_start;
    logic               r_wr_bank;
    logic               r_rd_bank;
    logic [7:0]         r_frame_cnt;
    logic               r_timeout;

    vs_edge_det #(
        .VS_ACTIVE_LOW(VS_ACTIVE_LOW)
    ) u_vs_edge_det (
        .i_clk     (i_clk_24MHz),
        .i_rst     (i_rst),
        .i_en      (i_en),
        .i_vs      (i_vs),
        .o_vs_edge (w_vs_edge)
    );

    assign w_timer_exp = (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk_24MHz) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_cap_start <= 1'b0;
            r_fft_start <= 1'b0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b1;
            r_frame_cnt <= '0;
            r_timeout   <= 1'b0;
        end else if (i_en) begin
            r_cap_start <= 1'b0;
            r_fft_start <= 1'b0;
            case (r_state)
                // Sticky timeout doubles as the "aborted" marker: restart waits for vsync.
                IDLE: begin
                    if (!r_timeout || w_vs_edge) begin
                        r_state     <= CAPTURE;
                        r_cap_start <= 1'b1;
                        r_timer     <= '0;
                    end
                end
                CAPTURE: begin
                    if (i_cap_done && !r_cap_start) begin
                        r_state     <= FFT;
                        r_fft_start <= 1'b1;
                        r_timer     <= '0;
                    end else if (w_timer_exp) begin
                        r_state   <= IDLE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                FFT: begin
                    if (i_fft_done && !r_fft_start) begin
                        r_state <= WAIT_VS;
                    end else if (w_timer_exp) begin
                        r_state   <= IDLE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                WAIT_VS: begin
                    if (w_vs_edge) begin
                        r_state     <= SWAP;
                        r_wr_bank   <= ~r_wr_bank;
                        r_rd_bank   <= ~r_rd_bank;
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                    end
                end
                SWAP: begin
                    r_state     <= CAPTURE;
                    r_cap_start <= 1'b1;
                    r_timer     <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_cap_start = r_cap_start;
    assign o_fft_start = r_fft_start;
    assign o_wr_bank   = r_wr_bank;
    assign o_rd_bank   = r_rd_bank;
    assign o_frame_cnt = r_frame_cnt;
    assign o_timeout   = r_timeout;
    assign o_state     = r_state;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench: table of per-cycle vectors for one scheduler, hand sequences for
// frame-count wrap, mid-frame reset and timeout behaviour (second instance, short timeout).
module tb_fft_frame_scheduler;

    typedef struct {
        int reps;
        int en;
        int vs;
        int cap;
        int fft;
        int st;
        int cs;
        int fs;
        int wr;
        int cnt;
    } vec_t;

    logic       clk;
    int         n_checks;
    int         n_err;

    // main instance, default timeout
    logic       rst, en, vs, cap_done, fft_done;
    logic       cap_start, fft_start, wr_bank, rd_bank, timeout;
    logic [7:0] frame_cnt;
    logic [2:0] state;

    // short-timeout instance
    logic       t_rst, t_en, t_vs, t_cap_done, t_fft_done;
    logic       t_cap_start, t_fft_start, t_wr_bank, t_rd_bank, t_timeout;
    logic [7:0] t_frame_cnt;
    logic [2:0] t_state;

    fft_frame_scheduler u_dut (
        .i_clk_24MHz (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_vs        (vs),
        .o_cap_start (cap_start),
        .i_cap_done  (cap_done),
        .o_fft_start (fft_start),
        .i_fft_done  (fft_done),
        .o_wr_bank   (wr_bank),
        .o_rd_bank   (rd_bank),
        .o_frame_cnt (frame_cnt),
        .o_timeout   (timeout),
        .o_state     (state)
    );

    fft_frame_scheduler #(
        .TIMEOUT_CYCLES(16),
        .TIMER_W(5)
    ) u_dut_to (
        .i_clk_24MHz (clk),
        .i_rst       (t_rst),
        .i_en        (t_en),
        .i_vs        (t_vs),
        .o_cap_start (t_cap_start),
        .i_cap_done  (t_cap_done),
        .o_fft_start (t_fft_start),
        .i_fft_done  (t_fft_done),
        .o_wr_bank   (t_wr_bank),
        .o_rd_bank   (t_rd_bank),
        .o_frame_cnt (t_frame_cnt),
        .o_timeout   (t_timeout),
        .o_state     (t_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int e, input int v, input int c, input int f);
        en       = (e != 0);
        vs       = (v != 0);
        cap_done = (c != 0);
        fft_done = (f != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic t_tick(input int v, input int c, input int f);
        t_vs       = (v != 0);
        t_cap_done = (c != 0);
        t_fft_done = (f != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input int st, input int cs, input int fs,
                              input int wr, input int cnt);
        check({tag, ".state"}, 32'(state), st);
        check({tag, ".cap_start"}, 32'(cap_start), cs);
        check({tag, ".fft_start"}, 32'(fft_start), fs);
        check({tag, ".wr_bank"}, 32'(wr_bank), wr);
        check({tag, ".rd_bank"}, 32'(rd_bank), 32'(wr == 0 ? 1 : 0));
        check({tag, ".frame_cnt"}, 32'(frame_cnt), cnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int   exp_cnt;
        int   exp_wr;

        n_checks = 0;
        n_err    = 0;
        rst = 1'b1; en = 1'b1; vs = 1'b1; cap_done = 1'b0; fft_done = 1'b0;
        t_rst = 1'b1; t_en = 1'b1; t_vs = 1'b1; t_cap_done = 1'b0; t_fft_done = 1'b0;

        //                reps en vs cap fft  st cs fs wr cnt
        tbl.push_back(vec_t'{  1, 1, 1, 0, 0,  1, 1, 0, 0, 0});  // first cycle after reset
        tbl.push_back(vec_t'{  1, 1, 1, 1, 0,  1, 0, 0, 0, 0});  // cap_done with cap_start: ignored
        tbl.push_back(vec_t'{ 38, 1, 1, 0, 0,  1, 0, 0, 0, 0});
        tbl.push_back(vec_t'{  1, 1, 1, 1, 0,  2, 0, 1, 0, 0});  // cap_done @+40
        tbl.push_back(vec_t'{  1, 1, 1, 0, 1,  2, 0, 0, 0, 0});  // fft_done with fft_start: ignored
        tbl.push_back(vec_t'{  5, 1, 1, 0, 0,  2, 0, 0, 0, 0});
        tbl.push_back(vec_t'{  1, 1, 1, 1, 0,  2, 0, 0, 0, 0});  // cap_done in FFT ignored
        tbl.push_back(vec_t'{  1, 1, 1, 0, 1,  3, 0, 0, 0, 0});
        tbl.push_back(vec_t'{  1, 1, 1, 0, 1,  3, 0, 0, 0, 0});  // fft_done in WAIT_VS ignored
        tbl.push_back(vec_t'{  3, 1, 1, 0, 0,  3, 0, 0, 0, 0});
        tbl.push_back(vec_t'{  1, 1, 0, 0, 0,  4, 0, 0, 1, 1});  // vsync fall -> swap
        tbl.push_back(vec_t'{  1, 1, 0, 0, 0,  1, 1, 0, 1, 1});  // cap_start after SWAP
        tbl.push_back(vec_t'{  1, 1, 1, 0, 0,  1, 0, 0, 1, 1});
        tbl.push_back(vec_t'{  1, 1, 1, 1, 0,  2, 0, 1, 1, 1});
        tbl.push_back(vec_t'{  1, 1, 0, 0, 0,  2, 0, 0, 1, 1});  // vsync during FFT dropped
        tbl.push_back(vec_t'{  3, 1, 0, 0, 0,  2, 0, 0, 1, 1});
        tbl.push_back(vec_t'{  1, 1, 1, 0, 0,  2, 0, 0, 1, 1});
        tbl.push_back(vec_t'{  1, 1, 1, 0, 1,  3, 0, 0, 1, 1});
        tbl.push_back(vec_t'{  1, 1, 0, 0, 0,  4, 0, 0, 0, 2});  // next vsync swaps once
        tbl.push_back(vec_t'{  1, 1, 0, 0, 0,  1, 1, 0, 0, 2});
        tbl.push_back(vec_t'{  1, 1, 1, 0, 0,  1, 0, 0, 0, 2});
        tbl.push_back(vec_t'{  1, 1, 0, 0, 0,  1, 0, 0, 0, 2});  // vsync during CAPTURE dropped
        tbl.push_back(vec_t'{  1, 1, 1, 1, 0,  2, 0, 1, 0, 2});
        tbl.push_back(vec_t'{ 40, 0, 1, 0, 0,  2, 0, 1, 0, 2});  // disabled: pulse frozen
        tbl.push_back(vec_t'{ 20, 0, 0, 0, 0,  2, 0, 1, 0, 2});  // vsync toggles while disabled
        tbl.push_back(vec_t'{ 40, 0, 1, 0, 0,  2, 0, 1, 0, 2});
        tbl.push_back(vec_t'{  1, 1, 1, 0, 0,  2, 0, 0, 0, 2});
        tbl.push_back(vec_t'{  1, 1, 1, 0, 1,  3, 0, 0, 0, 2});
        tbl.push_back(vec_t'{  1, 1, 0, 0, 0,  4, 0, 0, 1, 3});
        tbl.push_back(vec_t'{  1, 1, 0, 0, 0,  1, 1, 0, 1, 3});
        tbl.push_back(vec_t'{  1, 1, 1, 0, 0,  1, 0, 0, 1, 3});

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_main("reset", 0, 0, 0, 0, 0);
        check("reset.timeout", 32'(timeout), 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                tick(tbl[i].en, tbl[i].vs, tbl[i].cap, tbl[i].fft);
                check_main($sformatf("vec%0d", i), tbl[i].st, tbl[i].cs, tbl[i].fs,
                           tbl[i].wr, tbl[i].cnt);
            end
        end

        // run frames until the counter wraps
        exp_cnt = 3;
        exp_wr  = 1;
        for (int fr = 0; fr < 253; fr++) begin
            tick(1, 1, 1, 0);
            check("frame.fft", 32'(state), 2);
            tick(1, 1, 0, 0);
            tick(1, 1, 0, 1);
            check("frame.wait", 32'(state), 3);
            tick(1, 0, 0, 0);
            exp_cnt = (exp_cnt + 1) % 256;
            exp_wr  = 1 - exp_wr;
            check_main("frame.swap", 4, 0, 0, exp_wr, exp_cnt);
            tick(1, 0, 0, 0);
            check("frame.cap_start", 32'(cap_start), 1);
            tick(1, 1, 0, 0);
        end
        check("wrap.frame_cnt", 32'(frame_cnt), 0);
        check("wrap.timeout", 32'(timeout), 0);

        // reset while waiting for vsync
        tick(1, 1, 1, 0);
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 1);
        check("prerst.state", 32'(state), 3);
        rst = 1'b1;
        tick(1, 1, 0, 0);
        check_main("midrst", 0, 0, 0, 0, 0);
        check("midrst.timeout", 32'(timeout), 0);
        rst = 1'b0;
        tick(1, 1, 0, 0);
        check_main("postrst", 1, 1, 0, 0, 0);

        // timeout instance: 16 cycles in CAPTURE, then abort
        t_rst = 1'b0;
        t_tick(1, 0, 0);
        check("to.entry.state", 32'(t_state), 1);
        check("to.entry.cap_start", 32'(t_cap_start), 1);
        for (int k = 2; k <= 16; k++) begin
            t_tick(1, 0, 0);
            check("to.capture.state", 32'(t_state), 1);
            check("to.capture.timeout", 32'(t_timeout), 0);
        end
        t_tick(1, 0, 0);
        check("to.abort.state", 32'(t_state), 0);
        check("to.abort.timeout", 32'(t_timeout), 1);
        check("to.abort.wr_bank", 32'(t_wr_bank), 0);
        check("to.abort.rd_bank", 32'(t_rd_bank), 1);
        for (int k = 0; k < 3; k++) begin
            t_tick(1, 0, 0);
            check("to.idle.state", 32'(t_state), 0);
        end
        t_tick(0, 0, 0);
        check("to.restart.state", 32'(t_state), 1);
        check("to.restart.cap_start", 32'(t_cap_start), 1);
        check("to.restart.timeout", 32'(t_timeout), 1);
        t_tick(0, 0, 0);
        t_tick(0, 1, 0);
        check("to.fft.state", 32'(t_state), 2);
        for (int k = 0; k < 15; k++) begin
            t_tick(0, 0, 0);
            check("to.fft_hold.state", 32'(t_state), 2);
        end
        // timer at its limit and done in the same cycle: done wins
        t_tick(0, 0, 1);
        check("to.done_wins.state", 32'(t_state), 3);
        t_tick(1, 0, 0);
        t_tick(0, 0, 0);
        check("to.swap.state", 32'(t_state), 4);
        check("to.swap.wr_bank", 32'(t_wr_bank), 1);
        check("to.swap.rd_bank", 32'(t_rd_bank), 0);
        check("to.swap.frame_cnt", 32'(t_frame_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
